// File: rtl/par_fifo_pkg.sv
// Shared definitions for the partition-tagged FIFO: controller states and release-rule modes.
package par_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } state_e;

    localparam int MODE_EQUAL   = 0;
    localparam int MODE_ORDERED = 1;

endpackage

// File: rtl/par_tagged_fifo_release_cmp.sv
// Release rule: decides whether the head entry's partition tag may be handed to the current reader.
module par_release_cmp
    import par_fifo_pkg::*;
#(
    parameter int PW   = 2,
    parameter int MODE = MODE_EQUAL
) (
    input  logic [PW-1:0] tag_i,
    input  logic [PW-1:0] reader_i,
    output logic          release_o
);

    generate
        if (MODE == MODE_ORDERED) begin : g_ordered
            assign release_o = (tag_i <= reader_i);
        end else begin : g_equal
            assign release_o = (tag_i == reader_i);
        end
    endgenerate

endmodule

// File: rtl/par_tagged_fifo.sv
// Partition-tagged FIFO: entries carry a partition tag and leave only when the release rule allows,
// strictly in order. A scrub request flushes the queue and zeroes every storage slot.
module par_tagged_fifo
    import par_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int NPAR  = 4,
    parameter int MODE  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [$clog2(NPAR)-1:0]    in_par,
    input  logic [$clog2(NPAR)-1:0]    rd_par,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(NPAR)-1:0]    out_par,
    input  logic                       scrub_req,
    output logic                       scrub_busy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       par_err
);

    localparam int PW = $clog2(NPAR);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [PW:0]   NPAR_C   = (PW+1)'(NPAR);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    tag_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    scrub_idx_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             par_err_q;

    logic idle_open;
    logic head_rel;
    logic accept;
    logic tag_ok;
    logic push;
    logic pop;

    par_release_cmp #(
        .PW   (PW),
        .MODE (MODE)
    ) u_release (
        .tag_i     (tag_q[rd_ptr_q]),
        .reader_i  (rd_par),
        .release_o (head_rel)
    );

    // A pending scrub request closes both ports in the same cycle it is raised.
    always_comb begin
        idle_open = (state_q == IDLE) && !scrub_req;
        in_ready  = idle_open && (count_q < DEPTH_C);
        out_valid = idle_open && (count_q != '0) && head_rel;
        accept    = in_valid && in_ready;
        tag_ok    = ({1'b0, in_par} < NPAR_C);
        push      = accept && tag_ok;
        pop       = out_valid && out_ready;
        out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
        out_par   = out_valid ? tag_q[rd_ptr_q] : '0;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    assign scrub_busy = (state_q == SCRUB);
    assign count      = count_q;
    assign par_err    = par_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            scrub_idx_q <= '0;
            count_q     <= '0;
            par_err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            par_err_q <= accept && !tag_ok;
            case (state_q)
                IDLE: begin
                    if (scrub_req) begin
                        state_q     <= SCRUB;
                        wr_ptr_q    <= '0;
                        rd_ptr_q    <= '0;
                        scrub_idx_q <= '0;
                        count_q     <= '0;
                    end else begin
                        if (push) begin
                            mem_q[wr_ptr_q] <= in_data;
                            tag_q[wr_ptr_q] <= in_par;
                            wr_ptr_q        <= wr_ptr_q + AW'(1);
                        end
                        if (pop) begin
                            rd_ptr_q <= rd_ptr_q + AW'(1);
                        end
                        count_q <= count_d;
                    end
                end
                SCRUB: begin
                    mem_q[scrub_idx_q] <= '0;
                    tag_q[scrub_idx_q] <= '0;
                    scrub_idx_q        <= scrub_idx_q + AW'(1);
                    if (scrub_idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/par_tagged_fifo.md
PAR_TAGGED_FIFO -- requirements
Module: par_tagged_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 4, entry count; a power of two and at least 2.
REQ-003 The block SHALL have parameter NPAR, default 4, partition count; at least 2; PW = $clog2(NPAR), AW = $clog2(DEPTH).
REQ-004 The block SHALL have parameter MODE, default 0, release rule: 0 = equal partition, 1 = ordered (head tag <= reader).
REQ-005 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid  input  1  writer offers an entry.
REQ-008 The block SHALL have port in_ready  output  1  entry can be accepted.
REQ-009 The block SHALL have port in_data  input  WIDTH  write data.
REQ-010 The block SHALL have port in_par  input  PW  partition tag of write data.
REQ-011 The block SHALL have port rd_par  input  PW  current reader partition.
REQ-012 The block SHALL have port out_valid  output  1  head entry is releasable.
REQ-013 The block SHALL have port out_ready  input  1  reader takes head.
REQ-014 The block SHALL have port out_data  output  WIDTH  head data, zero when out_valid low.
REQ-015 The block SHALL have port out_par  output  PW  head tag, zero when out_valid low.
REQ-016 The block SHALL have port scrub_req  input  1  request flush-and-zero of all storage.
REQ-017 The block SHALL have port scrub_busy  output  1  scrub in progress.
REQ-018 The block SHALL have port count  output  AW+1  stored entries, 0..DEPTH.
REQ-019 The block SHALL have port par_err  output  1  registered one-cycle pulse for an out-of-range in_par.

Function
REQ-020 The block SHALL drive in_ready = (state==IDLE) && !scrub_req && (count < DEPTH).
REQ-021 The block SHALL store {in_data, in_par} at the tail when in_valid && in_ready && in_par < NPAR; first-in-first-out, no bypass: an entry written into an empty FIFO is visible one cycle later.
REQ-022 The block SHALL complete the handshake but discard the entry, and assert par_err the next cycle, when in_valid && in_ready && in_par >= NPAR.
REQ-023 The block SHALL drive out_valid = (state==IDLE) && !scrub_req && count>0 && release(head_tag, rd_par).
REQ-024 The block SHALL remove the head when out_valid && out_ready; a non-releasable head blocks all later entries (no reordering, no dropping).
REQ-025 The block SHALL allow a push and a pop in the same cycle, count unchanged; pointers wrap modulo DEPTH.
REQ-026 The block SHALL enter SCRUB on scrub_req in IDLE, clearing pointers and count that edge, then write zero data and zero tag to entries 0..DEPTH-1, one per cycle, returning to IDLE after exactly DEPTH cycles.
REQ-027 The block SHALL hold scrub_busy high exactly while in SCRUB, and ignore scrub_req while in SCRUB.
REQ-028 The block SHALL drive out_data and out_par to zero whenever out_valid is low, including while in SCRUB.

Reset
REQ-029 The block SHALL, on rst_n low, asynchronously clear state to IDLE and clear pointers, count, scrub counter, par_err, every storage entry and every tag.
REQ-030 The block SHALL, on reset asserted mid-scrub or mid-transfer, abandon the operation with no residual data on any output.

Structure
REQ-031 The block SHALL take its state encoding (IDLE, SCRUB) and MODE constants from shared package par_fifo_pkg.
REQ-032 The block SHALL instantiate a combinational sub-module par_release_cmp (inputs tag, reader, MODE) as its release-rule compare.

Verification
REQ-033 The bench SHALL cover: MODE=0, push 0xA5 with par 2, rd_par=2 -> out_valid next cycle, out_data 0xA5, count returns to 0 after pop.
REQ-034 The bench SHALL cover: MODE=0, push par 1 then par 2, rd_par=2 -> out_valid stays 0 and out_data stays 0 (head-of-line block); rd_par=1 -> both drain in order.
REQ-035 The bench SHALL cover: MODE=1, head par 1, rd_par=3 -> released; head par 3, rd_par=1 -> blocked.
REQ-036 The bench SHALL cover: fill DEPTH=4 -> in_ready 0 and count 4; simultaneous push/pop at count 3 -> count stays 3.
REQ-037 The bench SHALL cover: scrub_req with 3 entries stored -> scrub_busy high for 4 cycles, count 0, all storage reads zero afterwards, and no in_ready/out_valid during the request cycle.
REQ-038 The bench SHALL cover: NPAR=3, push with in_par 3 -> par_err pulse one cycle and count unchanged; rst_n low mid-scrub -> IDLE with count 0.
